aes_rd_stream_splitter: RTL and testbench

Upstream feeder for the AES AXI-stream wrapper. It takes the single 64-bit DMA read stream of one AES job (4 key words, then `num_blocks × 2` block words) and routes each word to the wrapper's key or block input channel. Each output channel has a one-entry register slice. The block sits between the DMA read engine and the AES wrapper. It tracks job progress and pulses `done_o` once every input word of the job has been forwarded.

---
 rtl/aes_pkg.sv | 16 +
 rtl/aes_rd_stream_splitter_if.sv | 27 ++
 rtl/aes_stream_slice.sv | 27 ++
 rtl/aes_rd_stream_splitter.sv | 133 +++++++++++++
 tb/tb_aes_rd_stream_splitter.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/aes_pkg.sv
// Shared AES stream constants and the splitter FSM state type.
// 3-bit state encoding keeps the same style as the wrapper FSM.
package aes_pkg;

    localparam int WORDSIZE        = 64;
    localparam int AES_KEY_WORDS   = 4;
    localparam int AES_BLOCK_WORDS = 2;

    typedef enum logic [2:0] {
        IDLE_S  = 3'd0,
        KEY_S   = 3'd1,
        BLOCK_S = 3'd2,
        DRAIN_S = 3'd3
    } split_state_t;

endpackage

// File: rtl/aes_rd_stream_splitter_if.sv
// DMA read stream plus key/block output streams of the splitter.
// master = the splitter itself; slave = DMA engine and wrapper sinks.
interface aes_rd_stream_splitter_if #(
    parameter int WORDSIZE = aes_pkg::WORDSIZE
);

    logic [WORDSIZE-1:0] dma_data_i;
    logic                dma_valid_i;
    logic                dma_ready_o;
    logic [WORDSIZE-1:0] key_data_o;
    logic                key_valid_o;
    logic                key_ready_i;
    logic [WORDSIZE-1:0] block_data_o;
    logic                block_valid_o;
    logic                block_ready_i;

    modport master (
        input  dma_data_i, dma_valid_i, key_ready_i, block_ready_i,
        output dma_ready_o, key_data_o, key_valid_o, block_data_o, block_valid_o
    );

    modport slave (
        output dma_data_i, dma_valid_i, key_ready_i, block_ready_i,
        input  dma_ready_o, key_data_o, key_valid_o, block_data_o, block_valid_o
    );

endinterface

// File: rtl/aes_stream_slice.sv
// One-entry valid/ready register slice; 1 cycle load-to-valid latency.
// Caller only loads when the slice is empty or draining this cycle.
module aes_stream_slice #(
    parameter int WORDSIZE = 64
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load,
    input  logic [WORDSIZE-1:0] load_data,
    input  logic                ready,
    output logic                valid,
    output logic [WORDSIZE-1:0] data
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= load_data;
        end else if (ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/aes_rd_stream_splitter.sv
// Routes one AES job's DMA words (key words, then block words) to key/block slices.
// Latency 1 cycle DMA->output; DMA ready follows the slice being filled, no dma_valid path.
module aes_rd_stream_splitter #(
    parameter int WORDSIZE    = aes_pkg::WORDSIZE,
    parameter int KEY_WORDS   = aes_pkg::AES_KEY_WORDS,
    parameter int BLOCK_WORDS = aes_pkg::AES_BLOCK_WORDS,
    parameter int NBLK_W      = 32
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic [NBLK_W-1:0] num_blocks_i,
    output logic              busy_o,
    output logic              done_o,
    aes_rd_stream_splitter_if.master bus
);

    import aes_pkg::*;

    localparam int WCNT_W = (KEY_WORDS > 1) ? $clog2(KEY_WORDS) : 1;
    localparam logic [WCNT_W-1:0] WCNT_ONE   = WCNT_W'(1);
    localparam logic [WCNT_W-1:0] KEY_LAST   = WCNT_W'(KEY_WORDS - 1);
    localparam logic [WCNT_W-1:0] BLOCK_LAST = WCNT_W'(BLOCK_WORDS - 1);
    localparam logic [NBLK_W-1:0] ONE_BLK    = NBLK_W'(1);

    split_state_t      state;
    logic [WCNT_W-1:0] word_cnt;
    logic [NBLK_W-1:0] blk_cnt;
    logic              dma_ready;
    logic              accept;
    logic              key_load;
    logic              block_load;
    logic              key_valid;
    logic              block_valid;
    logic              drained_next;

    always_comb begin
        dma_ready = 1'b0;
        case (state)
            KEY_S:   dma_ready = !key_valid || bus.key_ready_i;
            BLOCK_S: dma_ready = !block_valid || bus.block_ready_i;
            default: dma_ready = 1'b0;
        endcase
    end

    assign accept     = bus.dma_valid_i && dma_ready;
    assign key_load   = accept && (state == KEY_S);
    assign block_load = accept && (state == BLOCK_S);

    // Nothing loads in DRAIN_S, so both slices are empty next cycle exactly when this holds;
    // registering done here makes it coincide with the first cycle both valids read 0.
    assign drained_next = (!key_valid || bus.key_ready_i) && (!block_valid || bus.block_ready_i);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state    <= IDLE_S;
            word_cnt <= '0;
            blk_cnt  <= '0;
            done_o   <= 1'b0;
            busy_o   <= 1'b0;
        end else begin
            done_o <= 1'b0;
            if (done_o) begin
                busy_o <= 1'b0;
            end
            case (state)
                IDLE_S: begin
                    if (start_i) begin
                        blk_cnt  <= num_blocks_i;
                        word_cnt <= '0;
                        busy_o   <= 1'b1;
                        state    <= KEY_S;
                    end
                end
                KEY_S: begin
                    if (accept) begin
                        if (word_cnt == KEY_LAST) begin
                            word_cnt <= '0;
                            state    <= (blk_cnt != '0) ? BLOCK_S : DRAIN_S;
                        end else begin
                            word_cnt <= word_cnt + WCNT_ONE;
                        end
                    end
                end
                BLOCK_S: begin
                    if (accept) begin
                        if (word_cnt == BLOCK_LAST) begin
                            word_cnt <= '0;
                            blk_cnt  <= blk_cnt - ONE_BLK;
                            if (blk_cnt == ONE_BLK) begin
                                state <= DRAIN_S;
                            end
                        end else begin
                            word_cnt <= word_cnt + WCNT_ONE;
                        end
                    end
                end
                DRAIN_S: begin
                    if (drained_next) begin
                        done_o <= 1'b1;
                        state  <= IDLE_S;
                    end
                end
                default: state <= IDLE_S;
            endcase
        end
    end

    aes_stream_slice #(.WORDSIZE(WORDSIZE)) u_key_slice (
        .clk       (clk_i),
        .rst_n     (rst_ni),
        .load      (key_load),
        .load_data (bus.dma_data_i),
        .ready     (bus.key_ready_i),
        .valid     (key_valid),
        .data      (bus.key_data_o)
    );

    aes_stream_slice #(.WORDSIZE(WORDSIZE)) u_block_slice (
        .clk       (clk_i),
        .rst_n     (rst_ni),
        .load      (block_load),
        .load_data (bus.dma_data_i),
        .ready     (bus.block_ready_i),
        .valid     (block_valid),
        .data      (bus.block_data_o)
    );

    assign bus.dma_ready_o   = dma_ready;
    assign bus.key_valid_o   = key_valid;
    assign bus.block_valid_o = block_valid;

endmodule

// File: tb/tb_aes_rd_stream_splitter.sv
// Directed + randomized job sequences checked against a queue-based job model.
module tb_aes_rd_stream_splitter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [31:0] num_blocks;
    logic        busy;
    logic        done;

    always #5 clk = ~clk;

    aes_rd_stream_splitter_if #(.WORDSIZE(64)) bus ();

    aes_rd_stream_splitter #(
        .WORDSIZE    (64),
        .KEY_WORDS   (4),
        .BLOCK_WORDS (2),
        .NBLK_W      (32)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .start_i      (start),
        .num_blocks_i (num_blocks),
        .busy_o       (busy),
        .done_o       (done),
        .bus          (bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int rdy_mode = 0;
    bit tog = 1'b0;

    logic [63:0] words[$];
    logic [63:0] key_obs[$];
    logic [63:0] blk_obs[$];
    int dma_cyc[$];
    int key_cyc[$];
    int blk_cyc[$];
    int done_cyc[$];
    int hold_viol = 0;
    int stall_viol = 0;
    int busy_viol = 0;

    logic        pkv, pkr, pbv, pbr;
    logic [63:0] pkd, pbd;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Sink ready driver
    initial begin
        bus.key_ready_i   = 1'b1;
        bus.block_ready_i = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                1: begin
                    bus.key_ready_i   = 1'($urandom_range(1));
                    bus.block_ready_i = 1'($urandom_range(1));
                end
                2: begin
                    tog               = !tog;
                    bus.key_ready_i   = 1'b1;
                    bus.block_ready_i = tog;
                end
                default: begin
                    bus.key_ready_i   = 1'b1;
                    bus.block_ready_i = 1'b1;
                end
            endcase
        end
    end

    // Handshake monitor
    initial begin
        pkv = 1'b0; pkr = 1'b0; pbv = 1'b0; pbr = 1'b0; pkd = '0; pbd = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst_n === 1'b1) begin
                if (bus.dma_valid_i && bus.dma_ready_o) dma_cyc.push_back(cyc);
                if (bus.key_valid_o && bus.key_ready_i) begin
                    key_obs.push_back(bus.key_data_o);
                    key_cyc.push_back(cyc);
                end
                if (bus.block_valid_o && bus.block_ready_i) begin
                    blk_obs.push_back(bus.block_data_o);
                    blk_cyc.push_back(cyc);
                end
                if (done) begin
                    done_cyc.push_back(cyc);
                    if (!busy) busy_viol++;
                end
                if (pkv && !pkr && !(bus.key_valid_o && bus.key_data_o === pkd)) hold_viol++;
                if (pbv && !pbr && !(bus.block_valid_o && bus.block_data_o === pbd)) hold_viol++;
                if (bus.block_valid_o && !bus.block_ready_i && bus.dma_ready_o) stall_viol++;
                pkv = bus.key_valid_o;   pkr = bus.key_ready_i;   pkd = bus.key_data_o;
                pbv = bus.block_valid_o; pbr = bus.block_ready_i; pbd = bus.block_data_o;
            end else begin
                pkv = 1'b0; pbv = 1'b0; pkr = 1'b0; pbr = 1'b0;
            end
        end
    end

    task automatic clear_obs();
        key_obs.delete(); blk_obs.delete();
        dma_cyc.delete(); key_cyc.delete(); blk_cyc.delete(); done_cyc.delete();
        hold_viol = 0; stall_viol = 0; busy_viol = 0;
    endtask

    task automatic pulse_start(input int nblk);
        start      = 1'b1;
        num_blocks = 32'(nblk);
        @(posedge clk);
        #1;
        start      = 1'b0;
        num_blocks = $urandom;
    endtask

    // Offer words[0..n-1] in order; a mid-job start with count 9 is raised while idx == ms_idx.
    task automatic send_words(input int n, input int gap_pct, input int ms_idx);
        int idx = 0;
        int guard = 0;
        bit hs;
        while (idx < n && guard < 4000) begin
            bus.dma_valid_i = ($urandom_range(99) >= gap_pct);
            bus.dma_data_i  = bus.dma_valid_i ? words[idx] : {$urandom, $urandom};
            start           = (idx == ms_idx);
            if (start) num_blocks = 32'd9;
            @(negedge clk);
            hs = bus.dma_valid_i && bus.dma_ready_o;
            @(posedge clk);
            #1;
            if (hs) idx++;
            guard++;
        end
        bus.dma_valid_i = 1'b0;
        start           = 1'b0;
        if (guard >= 4000) check("send_timeout", 64'(idx), 64'(n));
    endtask

    task automatic run_job(input string tag, input int nblk, input int gap_pct,
                           input int mode, input int ms_idx, input bit fixed);
        int n;
        int t;
        int last_out;
        n = 4 + 2 * nblk;
        words.delete();
        for (int i = 0; i < n; i++)
            words.push_back(fixed ? 64'((i + 1) * 17) : {$urandom, $urandom});
        clear_obs();
        rdy_mode = mode;
        pulse_start(nblk);
        check({tag, " busy_after_start"}, 64'(busy), 64'd1);
        send_words(n, gap_pct, ms_idx);
        t = 0;
        while (done_cyc.size() == 0 && t < 300) begin
            @(posedge clk);
            #1;
            t++;
        end
        // Keep offering data after the job: nothing more may be accepted.
        bus.dma_valid_i = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check({tag, " dma_ready_after_done"}, 64'(bus.dma_ready_o), 64'd0);
        bus.dma_valid_i = 1'b0;
        rdy_mode = 0;
        check({tag, " done_count"}, 64'(done_cyc.size()), 64'd1);
        check({tag, " dma_accepted"}, 64'(dma_cyc.size()), 64'(n));
        check({tag, " key_count"}, 64'(key_obs.size()), 64'd4);
        check({tag, " block_count"}, 64'(blk_obs.size()), 64'(2 * nblk));
        for (int i = 0; i < key_obs.size() && i < 4; i++)
            check({tag, $sformatf(" key_word%0d", i)}, key_obs[i], words[i]);
        for (int i = 0; i < blk_obs.size() && i < 2 * nblk; i++)
            check({tag, $sformatf(" block_word%0d", i)}, blk_obs[i], words[4 + i]);
        if (done_cyc.size() > 0 && dma_cyc.size() > 0) begin
            if (mode == 0) begin
                check({tag, " done_timing"}, 64'(done_cyc[0]), 64'(dma_cyc[dma_cyc.size() - 1] + 2));
            end else begin
                last_out = key_cyc.size() > 0 ? key_cyc[key_cyc.size() - 1] : 0;
                if (blk_cyc.size() > 0 && blk_cyc[blk_cyc.size() - 1] > last_out)
                    last_out = blk_cyc[blk_cyc.size() - 1];
                check({tag, " done_window"},
                      64'(done_cyc[0] > last_out && done_cyc[0] <= last_out + 2), 64'd1);
            end
        end
        check({tag, " hold_violations"}, 64'(hold_viol), 64'd0);
        check({tag, " stall_violations"}, 64'(stall_viol), 64'd0);
        check({tag, " busy_at_done"}, 64'(busy_viol), 64'd0);
        check({tag, " busy_idle"}, 64'(busy), 64'd0);
    endtask

    initial begin
        rst_n           = 1'b0;
        start           = 1'b0;
        num_blocks      = '0;
        bus.dma_valid_i = 1'b0;
        bus.dma_data_i  = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst dma_ready",   64'(bus.dma_ready_o),   64'd0);
        check("rst key_valid",   64'(bus.key_valid_o),   64'd0);
        check("rst block_valid", 64'(bus.block_valid_o), 64'd0);
        check("rst done",        64'(done),              64'd0);
        check("rst busy",        64'(busy),              64'd0);
        check("rst key_data",    bus.key_data_o,         64'd0);
        check("rst block_data",  bus.block_data_o,       64'd0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        run_job("basic", 1, 0, 0, -1, 1'b1);
        run_job("zero_blocks", 0, 0, 0, -1, 1'b0);
        run_job("backpressure", 3, 0, 2, -1, 1'b0);
        run_job("ignored_start", 2, 0, 0, 5, 1'b0);

        // Reset after 3 key words of a 1-block job
        words.delete();
        for (int i = 0; i < 6; i++) words.push_back({$urandom, $urandom});
        clear_obs();
        rdy_mode = 0;
        pulse_start(1);
        send_words(3, 0, -1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("midrst dma_ready",   64'(bus.dma_ready_o),   64'd0);
        check("midrst key_valid",   64'(bus.key_valid_o),   64'd0);
        check("midrst block_valid", 64'(bus.block_valid_o), 64'd0);
        check("midrst done",        64'(done),              64'd0);
        check("midrst busy",        64'(busy),              64'd0);
        check("midrst key_data",    bus.key_data_o,         64'd0);
        check("midrst block_data",  bus.block_data_o,       64'd0);
        bus.dma_valid_i = 1'b1;
        bus.dma_data_i  = words[3];
        repeat (6) @(posedge clk);
        #1;
        bus.dma_valid_i = 1'b0;
        check("midrst no_done", 64'(done_cyc.size()), 64'd0);
        run_job("after_reset", 1, 0, 0, -1, 1'b0);

        run_job("throughput", 16, 0, 0, -1, 1'b0);
        if (dma_cyc.size() == 36)
            check("throughput span", 64'(dma_cyc[35] - dma_cyc[0]), 64'd35);

        for (int j = 0; j < 5; j++)
            run_job($sformatf("random%0d", j), int'($urandom_range(5)), 30, 1, -1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
